// File: rtl/neuron_address_generator.sv
// Address generator for a fully connected layer: walks input/weight memories
// one input/weight pair per cycle, then one bias weight per neuron.
module neuron_address_generator #(
  parameter int N_INPUTS  = 4,
  parameter int N_NEURONS = 3,
  parameter int IN_AW     = 4,
  parameter int W_AW      = 8,
  parameter int N_AW      = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            AG_rst,
  input  logic            AG_read,
  output logic [IN_AW-1:0] in_addr,
  output logic [W_AW-1:0]  w_addr,
  output logic             addr_valid,
  output logic             is_bias,
  output logic             neuron_last,
  output logic [N_AW-1:0]  neuron_idx,
  output logic             done
);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_BIAS = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [IN_AW-1:0] IDX_LAST = IN_AW'(N_INPUTS - 1);
  localparam logic [N_AW-1:0]  NEU_LAST = N_AW'(N_NEURONS - 1);
  localparam logic [W_AW-1:0]  BIAS_OFS = W_AW'(N_INPUTS);
  localparam logic [W_AW-1:0]  STRIDE   = W_AW'(N_INPUTS + 1);

  state_t            state_q, state_d;
  logic [IN_AW-1:0]  idx_q, idx_d;
  logic [N_AW-1:0]   neuron_q, neuron_d;
  logic [W_AW-1:0]   base_q, base_d;
  logic [IN_AW-1:0]  in_addr_q, in_addr_d;
  logic [W_AW-1:0]   w_addr_q, w_addr_d;
  logic              addr_valid_q, addr_valid_d;
  logic              is_bias_q, is_bias_d;
  logic              neuron_last_q, neuron_last_d;
  logic              done_q, done_d;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    neuron_d      = neuron_q;
    base_d        = base_q;
    in_addr_d     = in_addr_q;
    w_addr_d      = w_addr_q;
    addr_valid_d  = addr_valid_q;
    is_bias_d     = is_bias_q;
    neuron_last_d = neuron_last_q;
    done_d        = done_q;

    if (AG_rst) begin
      state_d       = S_HOLD;
      idx_d         = '0;
      neuron_d      = '0;
      base_d        = '0;
      in_addr_d     = '0;
      w_addr_d      = '0;
      addr_valid_d  = 1'b0;
      is_bias_d     = 1'b0;
      neuron_last_d = 1'b0;
      done_d        = 1'b0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (!AG_read) begin
            state_d      = S_RUN;
            idx_d        = '0;
            in_addr_d    = '0;
            w_addr_d     = base_q;
            addr_valid_d = 1'b1;
          end
        end
        S_RUN, S_BIAS: begin
          if (AG_read) begin
            // Rewind: the current neuron restarts, earlier neurons are kept.
            state_d       = S_HOLD;
            idx_d         = '0;
            in_addr_d     = '0;
            w_addr_d      = base_q;
            addr_valid_d  = 1'b0;
            is_bias_d     = 1'b0;
            neuron_last_d = 1'b0;
          end else if (state_q == S_RUN) begin
            if (idx_q != IDX_LAST) begin
              idx_d     = idx_q + 1'b1;
              in_addr_d = idx_q + 1'b1;
              w_addr_d  = w_addr_q + 1'b1;
            end else begin
              state_d       = S_BIAS;
              in_addr_d     = '0;
              w_addr_d      = base_q + BIAS_OFS;
              is_bias_d     = 1'b1;
              neuron_last_d = 1'b1;
            end
          end else if (neuron_q != NEU_LAST) begin
            state_d       = S_RUN;
            neuron_d      = neuron_q + 1'b1;
            base_d        = base_q + STRIDE;
            idx_d         = '0;
            in_addr_d     = '0;
            w_addr_d      = base_q + STRIDE;
            addr_valid_d  = 1'b1;
            is_bias_d     = 1'b0;
            neuron_last_d = 1'b0;
          end else begin
            state_d       = S_DONE;
            addr_valid_d  = 1'b0;
            is_bias_d     = 1'b0;
            neuron_last_d = 1'b0;
            done_d        = 1'b1;
          end
        end
        S_DONE: ;
        default: begin
          state_d       = S_HOLD;
          idx_d         = '0;
          neuron_d      = '0;
          base_d        = '0;
          in_addr_d     = '0;
          w_addr_d      = '0;
          addr_valid_d  = 1'b0;
          is_bias_d     = 1'b0;
          neuron_last_d = 1'b0;
          done_d        = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_HOLD;
      idx_q         <= '0;
      neuron_q      <= '0;
      base_q        <= '0;
      in_addr_q     <= '0;
      w_addr_q      <= '0;
      addr_valid_q  <= 1'b0;
      is_bias_q     <= 1'b0;
      neuron_last_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      neuron_q      <= neuron_d;
      base_q        <= base_d;
      in_addr_q     <= in_addr_d;
      w_addr_q      <= w_addr_d;
      addr_valid_q  <= addr_valid_d;
      is_bias_q     <= is_bias_d;
      neuron_last_q <= neuron_last_d;
      done_q        <= done_d;
    end
  end

  assign in_addr     = in_addr_q;
  assign w_addr      = w_addr_q;
  assign addr_valid  = addr_valid_q;
  assign is_bias     = is_bias_q;
  assign neuron_last = neuron_last_q;
  assign neuron_idx  = neuron_q;
  assign done        = done_q;

endmodule
